// File: rtl/stage_4_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface stage_4_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stage_4.sv
// RV32I memory-access stage: registers non-memory results through and runs one
// data-memory transaction per LOAD/STORE, stalling upstream until ack or timeout.
module stage_4 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        o_stall,
  stage_4_if.master   mem,
  output logic        o_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd_num,
  output logic        o_wb_en,
  output logic        o_misaligned,
  output logic        o_bus_err
);
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [31:0]       cap_addr, cap_data;
  logic [2:0]        cap_f3;
  logic [4:0]        cap_rd;
  logic              cap_store;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              timeout;
  logic              is_load, is_store, width_ok, align_ok, access_ok, writes_rd;
  logic [31:0]       lane, load_data;

  assign is_load   = (i_opcode == OPC_LOAD);
  assign is_store  = (i_opcode == OPC_STORE);
  assign writes_rd = i_opcode inside {OPC_OPIMM, OPC_OP, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};

  // NOTE: every signal assigned in an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    width_ok = 1'b0;
    align_ok = 1'b0;
    case (i_func_3)
      3'b000: begin width_ok = is_load | is_store; align_ok = 1'b1;                    end
      3'b001: begin width_ok = is_load | is_store; align_ok = ~i_alu_out[0];           end
      3'b010: begin width_ok = is_load | is_store; align_ok = (i_alu_out[1:0] == 2'b00); end
      3'b100: begin width_ok = is_load;            align_ok = 1'b1;                    end
      3'b101: begin width_ok = is_load;            align_ok = ~i_alu_out[0];           end
      default: ;
    endcase
  end
  assign access_ok = width_ok & align_ok;

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      IDLE: if (i_valid && i_op_type && access_ok) state_nx = BUSY;
      BUSY: begin
        // Ack on the final allowed cycle completes normally instead of timing out.
        if (mem.mem_ack) begin
          state_nx = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == CNT_LAST) begin
          state_nx = IDLE;
          timeout  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem.mem_req = (state == BUSY);
  assign o_stall     = (state == BUSY);

  always_comb begin
    mem.mem_addr  = '0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = '0;
    mem.mem_be    = '0;
    if (state == BUSY) begin
      mem.mem_addr = {cap_addr[31:2], 2'b00};
      mem.mem_we   = cap_store;
      if (cap_store) begin
        case (cap_f3[1:0])
          2'b00:   begin mem.mem_be = 4'b0001 << cap_addr[1:0]; mem.mem_wdata = {4{cap_data[7:0]}};  end
          2'b01:   begin mem.mem_be = 4'b0011 << cap_addr[1:0]; mem.mem_wdata = {2{cap_data[15:0]}}; end
          default: begin mem.mem_be = 4'b1111;                  mem.mem_wdata = cap_data;            end
        endcase
      end
    end
  end

  // Bring the addressed lane down to bit 0, then extend by width and signedness.
  assign lane = mem.mem_rdata >> {cap_addr[1:0], 3'b000};
  always_comb begin
    load_data = lane;
    case (cap_f3)
      3'b000:  load_data = {{24{lane[7]}},  lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_addr     <= '0;
      cap_data     <= '0;
      cap_f3       <= '0;
      cap_rd       <= '0;
      cap_store    <= 1'b0;
      tmo_cnt      <= '0;
      o_valid      <= 1'b0;
      o_wb_data    <= '0;
      o_rd_num     <= '0;
      o_wb_en      <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_wb_en      <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      if (state == IDLE) begin
        if (i_valid && !i_op_type) begin
          o_valid   <= 1'b1;
          o_wb_data <= i_alu_out;
          o_rd_num  <= i_rd_num;
          o_wb_en   <= writes_rd && (i_rd_num != 5'd0);
        end else if (i_valid && !access_ok) begin
          o_valid      <= 1'b1;
          o_misaligned <= 1'b1;
          o_wb_data    <= '0;
          o_rd_num     <= i_rd_num;
        end else if (i_valid) begin
          cap_addr  <= i_alu_out;
          cap_data  <= i_rs_2;
          cap_f3    <= i_func_3;
          cap_rd    <= i_rd_num;
          cap_store <= is_store;
          tmo_cnt   <= '0;
        end
      end else if (mem.mem_ack) begin
        o_valid   <= 1'b1;
        o_rd_num  <= cap_rd;
        o_wb_en   <= !cap_store && (cap_rd != 5'd0);
        o_wb_data <= cap_store ? 32'd0 : load_data;
      end else if (timeout) begin
        o_valid   <= 1'b1;
        o_bus_err <= 1'b1;
        o_wb_data <= '0;
        o_rd_num  <= cap_rd;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stage_4.sv
// Randomized bench for stage_4: each instruction is issued alone and its bus
// activity and writeback are compared with a byte/width-level reference model.
module tb_stage_4;
  localparam int TMO = 4;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  logic        clk, reset;
  logic        i_valid, i_op_type;
  logic [31:0] i_alu_out, i_rs_2;
  logic [4:0]  i_rd_num;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        o_stall, o_valid, o_wb_en, o_misaligned, o_bus_err;
  logic [31:0] o_wb_data;
  logic [4:0]  o_rd_num;
  int          n_checks = 0;
  int          n_pass = 0;

  stage_4_if bus ();

  stage_4 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_alu_out(i_alu_out), .i_rs_2(i_rs_2),
    .i_rd_num(i_rd_num), .i_opcode(i_opcode), .i_func_3(i_func_3), .i_op_type(i_op_type),
    .o_stall(o_stall), .mem(bus), .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd_num(o_rd_num),
    .o_wb_en(o_wb_en), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Bytes moved by an access; 0 marks a width the opcode does not define.
  function automatic int access_bytes(input logic [6:0] opc, input logic [2:0] f3);
    if (opc == OPC_LOAD)
      case (f3) 3'd0, 3'd4: return 1; 3'd1, 3'd5: return 2; 3'd2: return 4; default: return 0; endcase
    if (opc == OPC_STORE)
      case (f3) 3'd0: return 1; 3'd1: return 2; 3'd2: return 4; default: return 0; endcase
    return 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned nb   = access_bytes(OPC_LOAD, f3);
    int unsigned bits = 8 * nb;
    logic [31:0] v    = word >> (8 * addr[1:0]);
    if (nb == 4) return word;
    v = v % (32'd1 << bits);
    if (!f3[2] && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic writes_reg(input logic [6:0] opc);
    return opc inside {7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  // Issue one instruction, respond on the bus at ack_cycle (beyond TMO = never), check everything.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input int ack_cycle, input logic [31:0] rdata, input logic spur_ack,
                        output logic [31:0] wb_got);
    int          nb       = access_bytes(opc, f3);
    logic        is_mem   = (opc == OPC_LOAD) || (opc == OPC_STORE);
    logic        is_st    = (opc == OPC_STORE);
    logic        legal    = (nb != 0) && (alu % nb == 0);
    logic [3:0]  exp_be   = is_st ? 4'(((1 << nb) - 1) << alu[1:0]) : 4'b0000;
    logic [31:0] exp_wd   = (nb == 1) ? (rs2 % 256) * 32'h0101_0101 :
                            (nb == 2) ? (rs2 % 65536) * 32'h0001_0001 : rs2;
    logic        timed_out = ack_cycle > TMO;
    @(negedge clk);
    check({tag, ".idle_valid"}, o_valid, 1'b0);
    i_valid = 1'b1; i_opcode = opc; i_func_3 = f3; i_alu_out = alu; i_rs_2 = rs2;
    i_rd_num = rd; i_op_type = is_mem; bus.mem_ack = spur_ack; bus.mem_rdata = $urandom;
    @(negedge clk);
    i_valid = 1'b0; bus.mem_ack = 1'b0;
    if (!is_mem || !legal) begin
      check({tag, ".valid"}, o_valid, 1'b1);
      check({tag, ".misal"}, o_misaligned, is_mem);
      check({tag, ".buserr"}, o_bus_err, 1'b0);
      check({tag, ".wb_en"}, o_wb_en, !is_mem && writes_reg(opc) && rd != 0);
      if (!is_mem) check({tag, ".wb_data"}, o_wb_data, alu);
      if (!is_mem) check({tag, ".rd"}, o_rd_num, rd);
      check({tag, ".no_req"}, bus.mem_req, 1'b0);
      check({tag, ".no_stall"}, o_stall, 1'b0);
    end else begin
      for (int c = 1; c <= TMO; c++) begin
        check({tag, ".req"}, bus.mem_req, 1'b1);
        check({tag, ".stall"}, o_stall, 1'b1);
        check({tag, ".no_valid"}, o_valid, 1'b0);
        if (c == 1) begin
          check({tag, ".addr"}, bus.mem_addr, alu - (alu % 4));
          check({tag, ".we"}, bus.mem_we, is_st);
          check({tag, ".be"}, bus.mem_be, exp_be);
          if (is_st) check({tag, ".wdata"}, bus.mem_wdata, exp_wd);
        end
        if (c == ack_cycle) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdata; end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (c == ack_cycle) break;
      end
      check({tag, ".valid"}, o_valid, 1'b1);
      check({tag, ".buserr"}, o_bus_err, timed_out);
      check({tag, ".misal"}, o_misaligned, 1'b0);
      check({tag, ".wb_en"}, o_wb_en, !timed_out && !is_st && rd != 0);
      if (!timed_out) check({tag, ".wb_data"}, o_wb_data, is_st ? 32'd0 : load_value(f3, alu, rdata));
      if (!timed_out) check({tag, ".rd"}, o_rd_num, rd);
      check({tag, ".req_drop"}, bus.mem_req, 1'b0);
      check({tag, ".stall_drop"}, o_stall, 1'b0);
    end
    wb_got = o_wb_data;
  endtask

  initial begin
    logic [31:0] got;
    logic [6:0]  other_ops [9];
    other_ops = '{7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111, 7'b0110111,
                  7'b0010111, 7'b1100011, 7'b1110011, 7'b0001111};
    reset = 1'b1; i_valid = 1'b0; i_op_type = 1'b0; i_alu_out = '0; i_rs_2 = '0;
    i_rd_num = '0; i_opcode = '0; i_func_3 = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst.valid", o_valid, 1'b0);
    check("rst.wb_en", o_wb_en, 1'b0);
    check("rst.wb_data", o_wb_data, 32'd0);
    check("rst.req", bus.mem_req, 1'b0);
    check("rst.stall", o_stall, 1'b0);
    check("rst.flags", {o_misaligned, o_bus_err}, 2'b00);
    reset = 1'b0;

    run_op("addi", OPC_OPIMM, 3'd0, 32'h1234, 32'd0, 5'd5, 0, 32'd0, 1'b0, got);
    check("addi.spec", got, 32'h1234);
    run_op("addi_x0", OPC_OPIMM, 3'd0, 32'h1234, 32'd0, 5'd0, 0, 32'd0, 1'b0, got);
    run_op("lb", OPC_LOAD, 3'b000, 32'h103, 32'd0, 5'd7, 3, 32'h80FF_FFFF, 1'b0, got);
    check("lb.spec", got, 32'hFFFF_FF80);
    run_op("lbu", OPC_LOAD, 3'b100, 32'h103, 32'd0, 5'd7, 3, 32'h80FF_FFFF, 1'b0, got);
    check("lbu.spec", got, 32'h0000_0080);
    run_op("sh", OPC_STORE, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd0, 1, 32'd0, 1'b0, got);
    run_op("lw_mis", OPC_LOAD, 3'b010, 32'h101, 32'd0, 5'd3, 0, 32'd0, 1'b0, got);
    run_op("sw_mis", OPC_STORE, 3'b010, 32'h102, 32'd1, 5'd0, 0, 32'd0, 1'b0, got);
    run_op("tmo", OPC_LOAD, 3'b010, 32'h300, 32'd0, 5'd9, TMO + 1, 32'd0, 1'b0, got);
    run_op("ack_last", OPC_LOAD, 3'b010, 32'h300, 32'd0, 5'd9, TMO, 32'hCAFE_F00D, 1'b0, got);
    check("ack_last.spec", got, 32'hCAFE_F00D);

    for (int i = 0; i < 150; i++) begin
      int          kind = $urandom_range(0, 2);
      logic [6:0]  opc  = (kind == 0) ? other_ops[$urandom_range(0, 8)] :
                          (kind == 1) ? OPC_LOAD : OPC_STORE;
      logic [4:0]  rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_op("rand", opc, 3'($urandom), $urandom, $urandom, rd, $urandom_range(1, TMO + 1),
             $urandom, 1'($urandom_range(0, 3) == 0), got);
    end

    // Reset in the middle of a transaction, then a stale ack.
    @(negedge clk);
    i_valid = 1'b1; i_opcode = OPC_LOAD; i_func_3 = 3'b010; i_alu_out = 32'h40;
    i_rd_num = 5'd4; i_op_type = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    check("mid.req", bus.mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid.req_drop", bus.mem_req, 1'b0);
    check("mid.stall", o_stall, 1'b0);
    check("mid.addr", bus.mem_addr, 32'd0);
    check("mid.outs", {o_valid, o_wb_en, o_misaligned, o_bus_err, o_rd_num}, 9'd0);
    check("mid.wb_data", o_wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("late_ack.valid", o_valid, 1'b0);
    check("late_ack.req", bus.mem_req, 1'b0);
    @(negedge clk);
    check("late_ack.valid2", o_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
